// File: rtl/ps2_controller.sv
// PS/2 receiver: synchronised, glitch-filtered clock, frame checks, timeout.
// Define PS2_CONTROLLER_TX_EN to add host-to-device command transmit.
module ps2_controller #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
`ifdef PS2_CONTROLLER_TX_EN
  input  logic [7:0] the_command,
  input  logic       send_command,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
`endif
  output logic [7:0] received_data,
  output logic       received_data_en
);

  localparam int RX_TO = CLK_FREQ_HZ / 5000;
  localparam int FW    = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } rx_state_t;

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          dat;
  logic          flt;
  logic          flt_q;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic          tx_busy;
  logic          rx_edge;

  rx_state_t     rx_state;
  rx_state_t     rx_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [31:0]   rx_tmr;
  logic          rx_to;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], PS2_CLK};
      dat_s <= {dat_s[0], PS2_DAT};
    end
  end

  assign dat = dat_s[1];

  // Level only flips after FILTER_LEN consecutive opposing samples
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      flt     <= 1'b1;
      flt_q   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      flt_q <= flt;
      if (clk_s[1] == flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt     <= clk_s[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall    = flt_q & ~flt;
  assign rx_edge = fall & ~tx_busy;
  assign rx_to   = (rx_state != IDLE) &&
                   (rx_tmr == 32'(RX_TO - 1));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (rx_to) begin
      rx_next = IDLE;
    end else if (rx_edge) begin
      unique case (rx_state)
        IDLE:    if (!dat) rx_next = DATA;
        DATA:    if (bit_cnt == 3'd7) rx_next = PARITY;
        PARITY:  rx_next = STOP;
        STOP:    rx_next = IDLE;
        default: rx_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bit_cnt          <= '0;
      shift            <= '0;
      par              <= 1'b0;
      rx_tmr           <= '0;
      received_data    <= '0;
      received_data_en <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      if (rx_state == IDLE || rx_edge) rx_tmr <= '0;
      else                             rx_tmr <= rx_tmr + 1'b1;
      if (rx_edge && !rx_to) begin
        unique case (rx_state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift   <= {dat, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par <= dat;
          STOP: begin
            if (dat && (^{shift, par})) begin
              received_data    <= shift;
              received_data_en <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_CONTROLLER_TX_EN
  localparam int INH   = CLK_FREQ_HZ / 10000;
  localparam int TX_TO = CLK_FREQ_HZ / 66;

  typedef enum logic [2:0] {
    T_IDLE, T_INHIBIT, T_REQ, T_SEND, T_ACK
  } tx_state_t;

  tx_state_t   tx_state;
  tx_state_t   tx_next;
  logic [31:0] tx_tmr;
  logic [9:0]  tx_bits;
  logic [3:0]  tx_cnt;
  logic        tx_out;
  logic        tx_start;
  logic        tx_to;
  logic        inh_done;
  logic        clk_oe;
  logic        dat_oe;

  assign tx_busy  = tx_state != T_IDLE;
  assign tx_start = (tx_state == T_IDLE) && (rx_state == IDLE) &&
                    send_command;
  assign tx_to    = tx_busy && (tx_tmr == 32'(TX_TO - 1));
  assign inh_done = tx_tmr == 32'(INH - 1);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) tx_state <= T_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    if (tx_to) begin
      tx_next = T_IDLE;
    end else begin
      unique case (tx_state)
        T_IDLE:    if (tx_start) tx_next = T_INHIBIT;
        T_INHIBIT: if (inh_done) tx_next = T_REQ;
        T_REQ:     if (fall) tx_next = T_SEND;
        T_SEND:    if (fall && tx_cnt == 4'd9) tx_next = T_ACK;
        T_ACK:     if (fall && !dat) tx_next = T_IDLE;
        default:   tx_next = T_IDLE;
      endcase
    end
  end

  // tx_bits holds {stop, odd parity, command}, shifted out one per edge
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      tx_tmr                        <= '0;
      tx_bits                       <= '0;
      tx_cnt                        <= '0;
      tx_out                        <= 1'b1;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
    end else begin
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= tx_to;
      if (!tx_busy) tx_tmr <= '0;
      else          tx_tmr <= tx_tmr + 1'b1;
      if (tx_start) begin
        tx_bits <= {1'b1, ~^the_command, the_command};
        tx_cnt  <= '0;
        tx_out  <= 1'b1;
      end else if (fall && !tx_to &&
                   (tx_state == T_REQ || tx_state == T_SEND)) begin
        tx_out  <= tx_bits[0];
        tx_bits <= {1'b1, tx_bits[9:1]};
        tx_cnt  <= tx_cnt + 1'b1;
      end
      if (tx_state == T_ACK && fall && !dat && !tx_to)
        command_was_sent <= 1'b1;
    end
  end

  // Data goes low one cycle before the clock is released
  assign clk_oe = tx_state == T_INHIBIT;
  assign dat_oe = (tx_state == T_INHIBIT && inh_done) ||
                  (tx_state == T_REQ) ||
                  (tx_state == T_SEND && !tx_out);

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;
`else
  assign tx_busy = 1'b0;
  assign PS2_CLK = 1'bz;
  assign PS2_DAT = 1'bz;
`endif

endmodule

// File: tb/tb_ps2_controller.sv
// Directed bench for ps2_controller: device-side frames, glitches, timeouts.
// Exercises host transmit when PS2_CONTROLLER_TX_EN is defined.
`timescale 1ns/1ps
module tb_ps2_controller;

  localparam int FREQ = 25000000;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2_clk;
  wire        ps2_dat;
  logic [7:0] rx_data;
  logic       rx_en;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

`ifdef PS2_CONTROLLER_TX_EN
  logic [7:0] cmd = 8'h00;
  logic       send = 1'b0;
  logic       sent;
  logic       tout;
  int         sent_cnt = 0;
  int         tout_cnt = 0;
  always @(posedge clk) begin
    if (sent) sent_cnt++;
    if (tout) tout_cnt++;
  end
`endif

  ps2_controller #(
    .CLK_FREQ_HZ(FREQ),
    .FILTER_LEN (8)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (rst_n),
    .PS2_CLK         (ps2_clk),
    .PS2_DAT         (ps2_dat),
`ifdef PS2_CONTROLLER_TX_EN
    .the_command     (cmd),
    .send_command    (send),
    .command_was_sent(sent),
    .error_communication_timed_out(tout),
`endif
    .received_data   (rx_data),
    .received_data_en(rx_en)
  );

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int run = 0;
  int maxrun = 0;

  always @(posedge clk) begin
    if (rx_en === 1'b1) begin
      strobes++;
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input logic par,
                                        input logic stp);
    return {stp, par, b, 1'b0};
  endfunction

  // Device-to-host bits: data set while clock high, 10 us half-periods
  task automatic send_bits(input logic [10:0] f, input int n,
                           input bit glitch);
    for (int i = 0; i < n; i++) begin
      dev_dat_low = !f[i];
      if (glitch) begin
        #2000 dev_clk_low = 1'b1;
        #2 dev_clk_low = 1'b0;
        #2998;
      end else begin
        #5000;
      end
      dev_clk_low = 1'b1;
      if (glitch) begin
        #5000 dev_clk_low = 1'b0;
        #2 dev_clk_low = 1'b1;
        #4998;
      end else begin
        #10000;
      end
      dev_clk_low = 1'b0;
      #5000;
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic settle();
    #20000;
    @(negedge clk);
  endtask

  int s0;
`ifdef PS2_CONTROLLER_TX_EN
  longint t_lo, t_hi, t0;
  logic [9:0] bits;
  int sc0;
`endif

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_en", 32'(rx_en), 32'd0);
    chk("rst_clk_line", 32'(ps2_clk), 32'd1);
    chk("rst_dat_line", 32'(ps2_dat), 32'd1);
    rst_n = 1'b1;
    settle();

    s0 = strobes;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    settle();
    chk("1c_strobes", 32'(strobes - s0), 32'd1);
    chk("1c_data", 32'(rx_data), 32'h1C);
    chk("1c_width", 32'(maxrun), 32'd1);

    s0 = strobes;
    send_bits(frame(8'hF0, 1'b0, 1'b1), 11, 1'b0);
    settle();
    chk("bad_par_strobes", 32'(strobes - s0), 32'd0);
    chk("bad_par_data", 32'(rx_data), 32'h1C);

    s0 = strobes;
    send_bits(frame(8'h16, 1'b0, 1'b0), 11, 1'b0);
    settle();
    chk("bad_stop_strobes", 32'(strobes - s0), 32'd0);
    chk("bad_stop_data", 32'(rx_data), 32'h1C);

    s0 = strobes;
    send_bits(frame(8'h1E, 1'b1, 1'b1), 11, 1'b1);
    settle();
    chk("glitch_strobes", 32'(strobes - s0), 32'd1);
    chk("glitch_data", 32'(rx_data), 32'h1E);

    s0 = strobes;
    send_bits(frame(8'h25, 1'b0, 1'b1), 5, 1'b0);
    #300000;
    @(negedge clk);
    chk("partial_strobes", 32'(strobes - s0), 32'd0);
    send_bits(frame(8'h25, 1'b0, 1'b1), 11, 1'b0);
    settle();
    chk("resync_strobes", 32'(strobes - s0), 32'd1);
    chk("resync_data", 32'(rx_data), 32'h25);

    s0 = strobes;
    send_bits(frame(8'h2E, 1'b1, 1'b1), 4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_data", 32'(rx_data), 32'h00);
    chk("midrst_en", 32'(rx_en), 32'd0);
    rst_n = 1'b1;
    settle();
    send_bits(frame(8'h2E, 1'b1, 1'b1), 11, 1'b0);
    settle();
    chk("after_rst_strobes", 32'(strobes - s0), 32'd1);
    chk("after_rst_data", 32'(rx_data), 32'h2E);
    chk("strobe_width", 32'(maxrun), 32'd1);

`ifdef PS2_CONTROLLER_TX_EN
    cmd = 8'hED;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int k = 0; k < 1000 && ps2_clk !== 1'b0; k++) @(negedge clk);
    t_lo = $time;
    for (int k = 0; k < 5000 && ps2_clk !== 1'b1; k++) @(negedge clk);
    t_hi = $time;
    chk("inhibit_ns", 32'(t_hi - t_lo), 32'd100000);
    chk("start_bit", 32'(ps2_dat), 32'd0);
    #10000;
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      #10000;
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_dat;
      #10000;
      if (i == 9) dev_dat_low = 1'b1;
    end
    dev_dat_low = 1'b0;
    settle();
    chk("tx_byte", 32'(bits[7:0]), 32'hED);
    chk("tx_parity", 32'(bits[8]), 32'd1);
    chk("tx_stop", 32'(bits[9]), 32'd1);
    chk("tx_sent", 32'(sent_cnt), 32'd1);
    chk("tx_no_tout", 32'(tout_cnt), 32'd0);

    sc0 = sent_cnt;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    t0 = $time;
    for (int k = 0; k < 420000 && tout_cnt == 0; k++) @(negedge clk);
    chk("tout_pulse", 32'(tout_cnt), 32'd1);
    chk("tout_window",
        32'(($time - t0) > 64'd15000000 && ($time - t0) < 64'd15300000),
        32'd1);
    repeat (20) @(negedge clk);
    chk("tout_clk_rel", 32'(ps2_clk), 32'd1);
    chk("tout_dat_rel", 32'(ps2_dat), 32'd1);
    chk("tout_no_sent", 32'(sent_cnt - sc0), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
